// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit timing and line idle level.
package uart_pkg;

    // Receiver frame states, also exported on the debug state output.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_t;

    // 12 MHz system clock / 115200 baud.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;

    // Level of an idle (marking) serial line.
    localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte/strobe bundle from the UART receiver to its consumer (dictrl).
// Handshake: rx_data_rdy is a one-cycle valid strobe with no ready; rx_data is
// stable from that strobe until the next one, and the consumer must take the
// byte before the next frame completes or it is overwritten.
interface uart_rx_byte_if;
    import uart_pkg::*;

    logic [7:0]  rx_data;
    logic        rx_data_rdy;
    logic        rx_frame_err;
    logic        rx_busy;
    uart_state_t rx_state;

    // Receiver side drives the byte, strobes and debug state.
    modport master (
        output rx_data,
        output rx_data_rdy,
        output rx_frame_err,
        output rx_busy,
        output rx_state
    );

    // Consumer side only observes.
    modport slave (
        input rx_data,
        input rx_data_rdy,
        input rx_frame_err,
        input rx_busy,
        input rx_state
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with selectable reset level.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give metastability time to resolve before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: deframes the serial line into bytes with a one-cycle data
// strobe, and reports bad stop bits with a separate one-cycle error strobe.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           uart_rx,
    uart_rx_byte_if.master rx
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state;
    logic          rxs;
    logic [CW-1:0] clkcnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;

    sync2 #(
        .RESET_VAL (UART_IDLE_LVL)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (uart_rx),
        .q     (rxs)
    );

    assign rx.rx_state = state;

    // Frame FSM: mid-start qualification, then one sample per bit period; all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            clkcnt          <= '0;
            bitcnt          <= '0;
            shreg           <= '0;
            rx.rx_data      <= 8'h00;
            rx.rx_data_rdy  <= 1'b0;
            rx.rx_frame_err <= 1'b0;
            rx.rx_busy      <= 1'b0;
        end else begin
            rx.rx_data_rdy  <= 1'b0;
            rx.rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    clkcnt <= '0;
                    if (rxs != UART_IDLE_LVL) begin
                        state      <= START;
                        rx.rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (clkcnt == HALF_CNT) begin
                        clkcnt <= '0;
                        bitcnt <= '0;
                        if (rxs != UART_IDLE_LVL) begin
                            state <= DATA;
                        end else begin
                            // Line went back high before mid-start: treat as noise.
                            state      <= IDLE;
                            rx.rx_busy <= 1'b0;
                        end
                    end else begin
                        clkcnt <= clkcnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clkcnt == LAST_CNT) begin
                        clkcnt <= '0;
                        shreg  <= {rxs, shreg[7:1]};
                        if (bitcnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end else begin
                        clkcnt <= clkcnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clkcnt == LAST_CNT) begin
                        clkcnt <= '0;
                        if (rxs == UART_IDLE_LVL) begin
                            rx.rx_data     <= shreg;
                            rx.rx_data_rdy <= 1'b1;
                            state          <= IDLE;
                            rx.rx_busy     <= 1'b0;
                        end else begin
                            // Bad stop bit: drop the byte, wait out a possible break.
                            rx.rx_frame_err <= 1'b1;
                            state           <= WAIT_IDLE;
                        end
                    end else begin
                        clkcnt <= clkcnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    clkcnt <= '0;
                    if (rxs == UART_IDLE_LVL) begin
                        state      <= IDLE;
                        rx.rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    clkcnt     <= '0;
                    rx.rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed scenarios plus random frames,
// checked against a frame-level model (queue of expected bytes, error count, last byte).
module tb_uart_rx_byte;
    import uart_pkg::*;

    localparam int unsigned N = 104;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b1;

    uart_rx_byte_if rx_if ();

    uart_rx_byte #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .rx      (rx_if)
    );

    // Clock.
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state.
    logic [7:0] exp_q[$];
    int         exp_err  = 0;
    logic [7:0] exp_last = 8'h00;

    // Observed strobes.
    logic [7:0] rcv_q[$];
    int         err_cnt     = 0;
    int         overlap_cnt = 0;
    int         busy_bad    = 0;
    logic       prev_busy   = 1'b0;

    // Monitor: log every cycle a strobe is high, away from the active edge.
    always @(negedge clk) begin
        if (rx_if.rx_data_rdy) begin
            rcv_q.push_back(rx_if.rx_data);
            if (rx_if.rx_busy !== 1'b0 || prev_busy !== 1'b1) busy_bad++;
        end
        if (rx_if.rx_frame_err) err_cnt++;
        if (rx_if.rx_data_rdy && rx_if.rx_frame_err) overlap_cnt++;
        prev_busy = rx_if.rx_busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (N) @(negedge clk);
    endtask

    // Drive one 8N1 frame and update the model from the frame rules.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        if (stop) begin
            exp_q.push_back(b);
            exp_last = b;
        end else begin
            exp_err++;
        end
    endtask

    task automatic idle_line(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Compare received bytes against expected ones, then clear both.
    task automatic check_bytes(input string tag);
        int n;
        chk({tag, "_count"}, rcv_q.size(), exp_q.size());
        n = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_byte"}, rcv_q[i], exp_q[i]);
        rcv_q.delete();
        exp_q.delete();
        chk({tag, "_err_count"}, err_cnt, exp_err);
        chk({tag, "_rx_data"}, rx_if.rx_data, exp_last);
        chk({tag, "_busy_idle"}, rx_if.rx_busy, 1'b0);
    endtask

    initial begin
        // Reset held with a toggling line: outputs stay at reset values.
        repeat (5) begin
            repeat (10) @(negedge clk) uart_rx = 1'($urandom_range(0, 1));
            chk("reset_outputs", {rx_if.rx_data, rx_if.rx_data_rdy, rx_if.rx_frame_err, rx_if.rx_busy}, 32'h0);
        end
        chk("reset_state", rx_if.rx_state, IDLE);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        idle_line(3 * N);
        check_bytes("post_reset");

        // Single byte 'S'.
        send_frame(8'h53, 1'b1);
        idle_line(2 * N);
        check_bytes("byte_53");

        // 40-clock low glitch on the idle line.
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        idle_line(3 * N);
        check_bytes("glitch");
        chk("glitch_state", rx_if.rx_state, IDLE);

        // Bad stop bit followed by a 3-bit break.
        send_frame(8'h41, 1'b0);
        uart_rx = 1'b0;
        repeat (3 * N) @(negedge clk);
        chk("break_busy", rx_if.rx_busy, 1'b1);
        chk("break_err_once", err_cnt, exp_err);
        idle_line(2 * N);
        check_bytes("break");

        // Same byte after line recovers.
        send_frame(8'h41, 1'b1);
        idle_line(2 * N);
        check_bytes("after_break");

        // Back-to-back frames, no idle gap.
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h0D, 1'b1);
        idle_line(2 * N);
        check_bytes("back_to_back");

        // Random bytes with random gaps, including zero.
        for (int k = 0; k < 8; k++) begin
            send_frame(8'($urandom()), 1'b1);
            idle_line(int'($urandom_range(0, 2 * N)));
        end
        idle_line(2 * N);
        check_bytes("random");

        // Reset during data bit 4 of 0xA5.
        begin
            logic [7:0] b;
            b = 8'hA5;
            send_bit(1'b0);
            for (int i = 0; i < 4; i++) send_bit(b[i]);
            uart_rx = b[4];
            repeat (N / 2) @(negedge clk);
            chk("busy_mid_frame", rx_if.rx_busy, 1'b1);
            rst = 1'b0;
            exp_last = 8'h00;
            repeat (3) @(negedge clk);
            chk("abort_reset_outputs", {rx_if.rx_data, rx_if.rx_data_rdy, rx_if.rx_frame_err, rx_if.rx_busy}, 32'h0);
            uart_rx = 1'b1;
            repeat (20) @(negedge clk);
            rst = 1'b1;
            idle_line(2 * N);
            check_bytes("abort");
        end

        send_frame(8'h4C, 1'b1);
        idle_line(2 * N);
        check_bytes("byte_4c");

        chk("strobe_overlap", overlap_cnt, 0);
        chk("busy_at_strobe", busy_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
